gate_truth_checker: RTL and testbench
=====================================

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, giving the cycles each input vector is held before sampling; the legal range SHALL be 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin one truth-table sweep.
REQ-005 The block SHALL have port a_o, output, 1 bit: the A operand driven to the gates under test.
REQ-006 The block SHALL have port b_o, output, 1 bit: the B operand driven to the gates under test.
REQ-007 The block SHALL have port gate_y, input, 7 bits: gate results ordered bit0 AND, 1 OR, 2 NOT(A), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of each sweep.
REQ-010 The block SHALL have port pass, output, 1 bit: the sweep verdict, valid from done until the next accepted start.
REQ-011 The block SHALL have port err_mask, output, 7 bits: per-gate sticky mismatch flags, using the gate_y bit order.

Function
REQ-012 The block SHALL implement FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-013 In IDLE, start=1 SHALL move the FSM to DRIVE, set vec=2'b00, clear err_mask and clear pass.
REQ-014 a_o SHALL equal vec[1] and b_o SHALL equal vec[0] in DRIVE and SAMPLE; both SHALL be 0 in IDLE and DONE.
REQ-015 DRIVE SHALL last exactly SETTLE_CYCLES cycles, timed by a 4-bit settle counter, and then go to SAMPLE.
REQ-016 SAMPLE SHALL last one cycle: it SHALL OR (gate_y XOR expected(vec)) into err_mask, where expected is AND a&b, OR a|b, NOT ~a, NAND ~(a&b), NOR ~(a|b), XOR a^b, XNOR ~(a^b).
REQ-017 From SAMPLE, if vec≠3 the FSM SHALL increment vec and go to DRIVE; if vec=3 it SHALL go to DONE.
REQ-018 DONE SHALL last one cycle with done=1 and pass=(final err_mask==0), then go to IDLE; pass and err_mask SHALL hold their values in IDLE.
REQ-019 busy SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and DONE.
REQ-020 Latency: with start accepted at edge k, done SHALL be high during the cycle following edge k+4*(SETTLE_CYCLES+1).
REQ-021 start SHALL be ignored in DRIVE, SAMPLE and DONE; it SHALL be accepted only in IDLE, including the cycle immediately after DONE.
REQ-022 vec SHALL never wrap past 3 within a sweep; exactly four vectors (00, 01, 10, 11) SHALL be sampled, in that order.

Reset
REQ-023 While rst_n=0, regardless of clk: FSM=IDLE, vec=0, settle counter=0, a_o=0, b_o=0, busy=0, done=0, pass=0, err_mask=0, and the optional outputs of REQ-026 =0.
REQ-024 A reset asserted mid-sweep SHALL abort the sweep with no done pulse; the next start after release SHALL run a full four-vector sweep.

Configuration
REQ-025 Macro GATE_CHK_FIRST_FAIL_EN SHALL compile in first-failure logging.
REQ-026 With the macro defined, the block SHALL add ports first_fail_valid (output, 1 bit) and first_fail_vec (output, 2 bits); both SHALL be cleared on start, and the first SAMPLE with any mismatch SHALL set first_fail_valid=1 and capture vec into first_fail_vec, sticky until the next start or reset.
REQ-027 Without the macro, those ports and their registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package gate_chk_pkg SHALL hold GATE_NUM=7, the gate bit-index constants (GATE_AND..GATE_XNOR), and the FSM state typedef.
REQ-029 Sub-module gate_ref_model (combinational, inputs a and b, output exp[6:0]) SHALL compute the expected vector and be instantiated once.

Verification
REQ-030 Ideal gates, SETTLE_CYCLES=1, start pulse -> done 8 edges after acceptance, pass=1, err_mask=7'h00.
REQ-031 AND output stuck at 1 -> err_mask=7'b0000001, pass=0; with the macro, first_fail_vec=2'b00 and first_fail_valid=1.
REQ-032 XOR and XNOR outputs swapped -> err_mask=7'b1100000, pass=0; with the macro, first_fail_vec=2'b00.
REQ-033 SETTLE_CYCLES=3 -> each {a_o,b_o} held 4 cycles (3 DRIVE + 1 SAMPLE), done 16 edges after acceptance.
REQ-034 start pulsed while busy and in the DONE cycle -> ignored; start in the next IDLE cycle -> accepted and err_mask cleared.
REQ-035 rst_n low at vec=2'b10 -> all outputs 0 immediately, no done pulse; start after release -> full sweep, pass=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared constants and FSM state type for the logic-gate truth-table checker.
package gate_chk_pkg;

   localparam int GATE_NUM  = 7;
   localparam int GATE_AND  = 0;
   localparam int GATE_OR   = 1;
   localparam int GATE_NOT  = 2;
   localparam int GATE_NAND = 3;
   localparam int GATE_NOR  = 4;
   localparam int GATE_XOR  = 5;
   localparam int GATE_XNOR = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DRIVE  = 2'b01,
      SAMPLE = 2'b10,
      DONE   = 2'b11
   } gate_chk_state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Golden combinational model of the seven two-input gates under test.
module gate_ref_model
   import gate_chk_pkg::*;
(
   input  logic                a,
   input  logic                b,
   output logic [GATE_NUM-1:0] exp
);

   // Expected result of every gate for the current operand pair
   always_comb begin
      exp            = {GATE_NUM{1'b0}};
      exp[GATE_AND]  = a & b;
      exp[GATE_OR]   = a | b;
      exp[GATE_NOT]  = ~a;
      exp[GATE_NAND] = ~(a & b);
      exp[GATE_NOR]  = ~(a | b);
      exp[GATE_XOR]  = a ^ b;
      exp[GATE_XNOR] = ~(a ^ b);
   end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps {a,b} through 00,01,10,11 and flags gates whose results disagree with the model.
// Optional first-failure logging is compiled in with GATE_CHK_FIRST_FAIL_EN.
module gate_truth_checker
   import gate_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                a_o,
   output logic                b_o,
   input  logic [GATE_NUM-1:0] gate_y,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [GATE_NUM-1:0] err_mask
`ifdef GATE_CHK_FIRST_FAIL_EN
   ,
   output logic                first_fail_valid,
   output logic [1:0]          first_fail_vec
`endif
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   gate_chk_state_e     state_r, state_nx_s;
   logic [1:0]          vec_r, vec_nx_s;
   logic [3:0]          settle_r, settle_nx_s;
   logic [GATE_NUM-1:0] err_r, err_nx_s;
   logic                pass_r, pass_nx_s;
   logic                busy_nx_s;
   logic                a_r, b_r, busy_r, done_r;
   logic [GATE_NUM-1:0] exp_s, mism_s;
`ifdef GATE_CHK_FIRST_FAIL_EN
   logic                ffv_r, ffv_nx_s;
   logic [1:0]          ffvec_r, ffvec_nx_s;
`endif

   gate_ref_model u_ref (
      .a   (vec_r[1]),
      .b   (vec_r[0]),
      .exp (exp_s)
   );

   assign mism_s = gate_y ^ exp_s;

   // Next-state, sweep bookkeeping and verdict decode
   always_comb begin
      state_nx_s  = state_r;
      vec_nx_s    = vec_r;
      settle_nx_s = settle_r;
      err_nx_s    = err_r;
      pass_nx_s   = pass_r;
`ifdef GATE_CHK_FIRST_FAIL_EN
      ffv_nx_s    = ffv_r;
      ffvec_nx_s  = ffvec_r;
`endif
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s  = DRIVE;
               vec_nx_s    = 2'b00;
               settle_nx_s = 4'd0;
               err_nx_s    = {GATE_NUM{1'b0}};
               pass_nx_s   = 1'b0;
`ifdef GATE_CHK_FIRST_FAIL_EN
               ffv_nx_s    = 1'b0;
               ffvec_nx_s  = 2'b00;
`endif
            end else begin
               state_nx_s = IDLE;
            end
         end
         DRIVE: begin
            if (settle_r == SETTLE_LAST) begin
               state_nx_s  = SAMPLE;
               settle_nx_s = 4'd0;
            end else begin
               settle_nx_s = settle_r + 4'd1;
            end
         end
         SAMPLE: begin
            err_nx_s = err_r | mism_s;
`ifdef GATE_CHK_FIRST_FAIL_EN
            if ((|mism_s) && !ffv_r) begin
               ffv_nx_s   = 1'b1;
               ffvec_nx_s = vec_r;
            end else begin
               ffv_nx_s   = ffv_r;
            end
`endif
            // The last vector ends the sweep instead of wrapping back to 00
            if (vec_r == 2'b11) begin
               state_nx_s = DONE;
               pass_nx_s  = (err_nx_s == {GATE_NUM{1'b0}});
            end else begin
               state_nx_s  = DRIVE;
               vec_nx_s    = vec_r + 2'b01;
               settle_nx_s = 4'd0;
            end
         end
         DONE: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s  = IDLE;
            vec_nx_s    = 2'b00;
            settle_nx_s = 4'd0;
         end
      endcase

      if ((state_nx_s == DRIVE) || (state_nx_s == SAMPLE)) begin
         busy_nx_s = 1'b1;
      end else begin
         busy_nx_s = 1'b0;
      end
   end

   // State, sweep registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         vec_r    <= 2'b00;
         settle_r <= 4'd0;
         err_r    <= {GATE_NUM{1'b0}};
         pass_r   <= 1'b0;
         a_r      <= 1'b0;
         b_r      <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
`ifdef GATE_CHK_FIRST_FAIL_EN
         ffv_r    <= 1'b0;
         ffvec_r  <= 2'b00;
`endif
      end else begin
         state_r  <= state_nx_s;
         vec_r    <= vec_nx_s;
         settle_r <= settle_nx_s;
         err_r    <= err_nx_s;
         pass_r   <= pass_nx_s;
         a_r      <= busy_nx_s & vec_nx_s[1];
         b_r      <= busy_nx_s & vec_nx_s[0];
         busy_r   <= busy_nx_s;
         done_r   <= (state_nx_s == DONE);
`ifdef GATE_CHK_FIRST_FAIL_EN
         ffv_r    <= ffv_nx_s;
         ffvec_r  <= ffvec_nx_s;
`endif
      end
   end

   assign a_o      = a_r;
   assign b_o      = b_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign pass     = pass_r;
   assign err_mask = err_r;
`ifdef GATE_CHK_FIRST_FAIL_EN
   assign first_fail_valid = ffv_r;
   assign first_fail_vec   = ffvec_r;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: two checkers (settle 1 and 3) driving a faultable behavioural gate bank.
module tb_gate_truth_checker;

   typedef struct {
      logic       pass;
      logic [6:0] err;
      logic       ffv;
      logic [1:0] ffvec;
      int         done_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start0 = 1'b0, start3 = 1'b0;
   logic       a0, b0, busy0, done0, pass0;
   logic       a3, b3, busy3, done3, pass3;
   logic [6:0] err0, err3, gy0, gy3;
   logic       ffv0, ffv3;
   logic [1:0] ffvec0, ffvec3;
   int         fault0 = 0;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   exp_t       q0[$];
   exp_t       q3[$];
   exp_t       e0, e3;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural gate bank: mode 1 AND stuck-1, 2 XOR/XNOR swapped, 3 NOT wired to B, 4 OR stuck-0
   function automatic logic [6:0] gates(input logic a, input logic b, input int mode);
      logic [6:0] g;
      g[0] = a & b;    g[1] = a | b;     g[2] = ~a;      g[3] = ~(a & b);
      g[4] = ~(a | b); g[5] = a ^ b;     g[6] = ~(a ^ b);
      case (mode)
         1: g[0] = 1'b1;
         2: begin g[5] = ~(a ^ b); g[6] = a ^ b; end
         3: g[2] = ~b;
         4: g[1] = 1'b0;
         default: ;
      endcase
      return g;
   endfunction

   assign gy0 = gates(a0, b0, fault0);
   assign gy3 = gates(a3, b3, 0);

   gate_truth_checker #(.SETTLE_CYCLES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .a_o(a0), .b_o(b0), .gate_y(gy0),
      .busy(busy0), .done(done0), .pass(pass0), .err_mask(err0)
`ifdef GATE_CHK_FIRST_FAIL_EN
      , .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
`endif
   );

   gate_truth_checker #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a_o(a3), .b_o(b3), .gate_y(gy3),
      .busy(busy3), .done(done3), .pass(pass3), .err_mask(err3)
`ifdef GATE_CHK_FIRST_FAIL_EN
      , .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
`endif
   );

`ifndef GATE_CHK_FIRST_FAIL_EN
   assign ffv0 = 1'b0; assign ffvec0 = 2'b00;
   assign ffv3 = 1'b0; assign ffvec3 = 2'b00;
`endif

   task automatic chk(input string name, input int act, input int expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic exp_t mk(input logic p, input logic [6:0] e, input logic v, input logic [1:0] fv);
      exp_t r;
      r.pass = p; r.err = e; r.ffv = v; r.ffvec = fv; r.done_cyc = 0;
      return r;
   endfunction

   // Monitor for the settle-1 instance
   always @(negedge clk) begin
      if (done0) begin
         if (q0.size() == 0) begin
            chk("unexpected_done0", 1, 0);
         end else begin
            e0 = q0.pop_front();
            chk("done0_cycle", cyc, e0.done_cyc);
            chk("pass0", int'(pass0), int'(e0.pass));
            chk("err_mask0", int'(err0), int'(e0.err));
`ifdef GATE_CHK_FIRST_FAIL_EN
            chk("ff_valid0", int'(ffv0), int'(e0.ffv));
            chk("ff_vec0", int'(ffvec0), int'(e0.ffvec));
`endif
         end
      end
   end

   // Monitor for the settle-3 instance
   always @(negedge clk) begin
      if (done3) begin
         if (q3.size() == 0) begin
            chk("unexpected_done3", 1, 0);
         end else begin
            e3 = q3.pop_front();
            chk("done3_cycle", cyc, e3.done_cyc);
            chk("pass3", int'(pass3), int'(e3.pass));
            chk("err_mask3", int'(err3), int'(e3.err));
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_a0"}, int'(a0), 0);       chk({tag, "_b0"}, int'(b0), 0);
      chk({tag, "_busy0"}, int'(busy0), 0); chk({tag, "_done0"}, int'(done0), 0);
      chk({tag, "_pass0"}, int'(pass0), 0); chk({tag, "_err0"}, int'(err0), 0);
      chk({tag, "_ffv0"}, int'(ffv0), 0);   chk({tag, "_ffvec0"}, int'(ffvec0), 0);
      chk({tag, "_busy3"}, int'(busy3), 0); chk({tag, "_err3"}, int'(err3), 0);
   endtask

   // Full directed sweep on the settle-1 instance with vector-order and hold checks
   task automatic run0(input int mode, input exp_t e);
      @(negedge clk);
      fault0 = mode;
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      e.done_cyc = cyc + 8;
      q0.push_back(e);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         chk("vec0_order", int'({a0, b0}), i / 2);
         chk("busy0_sweep", int'(busy0), 1);
      end
      @(negedge clk);
      chk("done0_cycle_busy", int'(busy0), 0);
      chk("done0_cycle_ab", int'({a0, b0}), 0);
      @(negedge clk);
      chk("idle_hold_pass0", int'(pass0), int'(e.pass));
      chk("idle_hold_err0", int'(err0), int'(e.err));
      chk("idle_done0_low", int'(done0), 0);
   endtask

   task automatic wait_done0(input string tag);
      for (int i = 0; i < 50 && !done0; i++) @(negedge clk);
      if (!done0) chk({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #23;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs_zero("post_reset_idle");

      // Directed sweeps with hand-derived verdicts
      run0(0, mk(1'b1, 7'b0000000, 1'b0, 2'b00));
      run0(1, mk(1'b0, 7'b0000001, 1'b1, 2'b00));
      run0(2, mk(1'b0, 7'b1100000, 1'b1, 2'b00));
      run0(3, mk(1'b0, 7'b0000100, 1'b1, 2'b01));
      run0(4, mk(1'b0, 7'b0000010, 1'b1, 2'b01));

      // start ignored while busy and in DONE, accepted in the following IDLE cycle
      @(negedge clk);
      fault0 = 1;
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      e0 = mk(1'b0, 7'b0000001, 1'b1, 2'b00);
      e0.done_cyc = cyc + 8;
      q0.push_back(e0);
      repeat (3) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_done0("ignore_test");
      fault0 = 0;
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("done_start_ignored_err", int'(err0), 7'b0000001);
      chk("done_start_ignored_busy", int'(busy0), 0);
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      chk("idle_start_err_cleared", int'(err0), 0);
      chk("idle_start_busy", int'(busy0), 1);
      e0 = mk(1'b1, 7'b0000000, 1'b0, 2'b00);
      e0.done_cyc = cyc + 8;
      q0.push_back(e0);
      wait_done0("after_ignore");
      @(negedge clk);

      // Reset asserted at vector 10 aborts the sweep
      fault0 = 1;
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      for (int i = 0; i < 20 && !(a0 && !b0); i++) @(negedge clk);
      chk("reached_vec10", int'({a0, b0}), 2);
      #2;
      rst_n = 1'b0;
      q0.delete();
      #1;
      check_outputs_zero("mid_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("no_done_after_abort", int'(done0), 0);
      end
      run0(0, mk(1'b1, 7'b0000000, 1'b0, 2'b00));

      // Settle-3 instance: each vector held four cycles, done 16 edges after acceptance
      @(negedge clk);
      start3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start3 = 1'b0;
      e3 = mk(1'b1, 7'b0000000, 1'b0, 2'b00);
      e3.done_cyc = cyc + 16;
      q3.push_back(e3);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         chk("vec3_hold", int'({a3, b3}), i / 4);
         chk("busy3_sweep", int'(busy3), 1);
      end

      for (int i = 0; i < 50 && (q0.size() != 0 || q3.size() != 0); i++) @(negedge clk);
      if (q0.size() != 0 || q3.size() != 0) chk("scoreboard_drain_timeout", 0, 1);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
